// File: rtl/rr_arb_mux_pkg.sv
// rtl/rr_arb_mux_pkg.sv - shared types and defaults for the round-robin arbitration mux
// Contents:
//   mode_e    : arbitration mode (MODE_RR round-robin, MODE_FIXED lowest index wins)
//   N_DEF     : default channel count
//   W_DEF     : default data width per channel
//   sel_width : select/grant index width, max(1, clog2(n))
package rr_arb_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  function automatic int sel_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - channel-side and output-side handshake bundle for rr_arb_mux
// Signals:
//   in_valid  [N]    per-channel request
//   in_data   [N*W]  packed channel data, channel i at [i*W +: W]
//   in_ready  [N]    per-channel accept, one-hot or zero
//   mode             0 round-robin, 1 fixed priority
//   out_valid        output register holds a word
//   out_data  [W]    selected word
//   out_sel   [SW]   channel index that supplied out_data
//   out_ready        downstream accept
// Modports: master = the side driving requests and out_ready; slave = the arbiter.
interface rr_arb_mux_if
  import rr_arb_mux_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int SW = sel_width(N)
);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational grant selection for rr_arb_mux
// Ports:
//   req   [N]   request vector
//   ptr   [SW]  round-robin start index (ignored in fixed mode)
//   mode        MODE_RR: first requester at or after ptr, wrapping; MODE_FIXED: lowest requester
//   grant [SW]  chosen index (0 when nothing requests)
//   any         at least one request present
module rr_arb_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  mode_e         mode,
  output logic [SW-1:0] grant,
  output logic          any
);

  int idx;

  // Both searches scan from the far end towards the preferred end so that the
  // last hit written is the winner; this avoids a break in the loop.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    if (mode == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant = SW'(i);
          any   = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % N;
        if (req[idx]) begin
          grant = SW'(idx);
          any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrated mux with a one-word registered output stage
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears the output word and the RR pointer
//   bus    rr_arb_mux_if.slave: in_valid/in_data/in_ready per channel, mode,
//          out_valid/out_data/out_sel/out_ready towards the consumer
// Optional build macro RR_ARB_MUX_XPROP_EN: out_data reads all-X while idle (after
// the first load), and an unknown mode blocks all grants and poisons out_data.
// Without it out_data holds its last value and an unknown mode acts as round-robin.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb_mux_if.slave bus
);

  localparam int SW = sel_width(N);

  logic          out_valid_q;
  logic [W-1:0]  data_q;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] grant;
  logic [SW-1:0] next_ptr;
  logic          any;
  logic          load;
  logic          xfer;
  logic          mode_unknown;
  mode_e         mode_eff;

`ifdef RR_ARB_MUX_XPROP_EN
  logic          loaded_q;
  assign mode_unknown = $isunknown(bus.mode);
`else
  assign mode_unknown = 1'b0;
`endif

  // An if on an unknown condition takes the else branch, so X/Z falls back to RR.
  always_comb begin
    if (bus.mode == 1'b1) mode_eff = MODE_FIXED;
    else                  mode_eff = MODE_RR;
  end

  rr_arb_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .mode  (mode_eff),
    .grant (grant),
    .any   (any)
  );

  // The output register can take a new word when empty or being drained this cycle.
  assign load     = !out_valid_q || bus.out_ready;
  assign xfer     = load && any && !mode_unknown;
  assign next_ptr = (int'(grant) == N - 1) ? '0 : grant + SW'(1);

  // rst_n gates in_ready directly because the cleared output stage would
  // otherwise advertise a grant while reset is still held.
  always_comb begin
    bus.in_ready = '0;
    if (xfer && rst_n) bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
`ifdef RR_ARB_MUX_XPROP_EN
      loaded_q    <= 1'b0;
`endif
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      data_q      <= bus.in_data[int'(grant)*W +: W];
      sel_q       <= grant;
      if (mode_eff == MODE_RR) ptr_q <= next_ptr;
`ifdef RR_ARB_MUX_XPROP_EN
      loaded_q    <= 1'b1;
`endif
    end
`ifdef RR_ARB_MUX_XPROP_EN
    else if (load && any && mode_unknown) begin
      // A grant would have happened but the mode is unknown: poison the word.
      out_valid_q <= 1'b0;
      data_q      <= {W{1'bx}};
      loaded_q    <= 1'b1;
    end
`endif
    else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = sel_q;
`ifdef RR_ARB_MUX_XPROP_EN
  assign bus.out_data  = (!out_valid_q && loaded_q) ? {W{1'bx}} : data_q;
`else
  assign bus.out_data  = data_q;
`endif

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of input channels (legal 2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning data width per channel (legal 1..64).
REQ-003 The block SHALL use derived constant SW = max(1, clog2(N)), the select/grant index width.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-005 in_valid  input  N  per-channel request.
REQ-006 in_data  input  N*W  packed channel data, channel i at bits [i*W +: W].
REQ-007 in_ready  output  N  per-channel accept, one-hot or zero.
REQ-008 mode  input  1  arbitration mode: 0 round-robin, 1 fixed priority.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_data  output  W  selected word.
REQ-011 out_sel  output  SW  index of channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 Transfer on a port SHALL occur when valid and ready are both 1 at a rising clk edge.
REQ-014 Load enable SHALL be load = !out_valid | out_ready; in_ready SHALL be all-zero when load = 0.
REQ-015 When load = 1 and any in_valid is 1, exactly one in_ready[g] SHALL be 1 in the same cycle (combinational from in_valid, mode, pointer); g is the grant.
REQ-016 Round-robin (mode 0): g SHALL be the first requesting index at or after pointer ptr, wrapping N-1 -> 0; after each transfer ptr SHALL become (g+1) mod N.
REQ-017 Fixed priority (mode 1): g SHALL be the lowest requesting index; ptr SHALL NOT change.
REQ-018 On input transfer, out_data <= in_data[g], out_sel <= g, out_valid <= 1 next edge; latency one cycle.
REQ-019 If out_ready = 1 and no input transfer, out_valid SHALL go 0; out_data and out_sel hold.
REQ-020 Simultaneous output drain and input transfer SHALL sustain one word per cycle with no bubble.
REQ-021 mode SHALL be sampled per cycle; a change takes effect on the next grant without flushing the output register.
REQ-022 If out_valid = 1 and out_ready = 0, out_data, out_sel, ptr SHALL stay stable.

Reset
REQ-023 On rst_n = 0, asynchronously: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0; in_ready SHALL be all-zero while rst_n = 0.
REQ-024 Reset asserted mid-transfer SHALL discard the held word; first grant after release starts from channel 0.

Configuration
REQ-025 Macro RR_ARB_MUX_XPROP_EN SHALL, when defined: drive out_data all-X while out_valid = 0 (after first load), and on mode X/Z drive in_ready all-zero and load out_data all-X if a transfer would occur.
REQ-026 Without RR_ARB_MUX_XPROP_EN: out_data holds last value when idle; mode X/Z SHALL be treated as 0 (round-robin).

Structure
REQ-027 Package rr_arb_mux_pkg SHALL hold the mode enum (MODE_RR=0, MODE_FIXED=1) and defaults N_DEF=4, W_DEF=8.
REQ-028 Grant computation SHALL be a sub-module rr_arb_pick (inputs req, ptr, mode; outputs grant index, any); data path stays in rr_arb_mux.

Verification
REQ-029 Reset: rst_n=0 mid-stream -> out_valid=0, out_data=0, out_sel=0, in_ready=4'b0000 immediately; after release, in_valid=4'b1111 -> first out_sel=0.
REQ-030 Round-robin fairness: mode=0, in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 one per cycle, no bubbles.
REQ-031 Wrap/skip: mode=0, ptr=3, in_valid=4'b0101 -> grant 0, then 2, then 0.
REQ-032 Fixed priority: mode=1, in_valid=4'b1110 held -> out_sel 1 every cycle; channels 2,3 never granted.
REQ-033 Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b0010 -> in_ready=0, out_data stable; out_ready=1 -> old word drains, channel 1 word appears next cycle.
REQ-034 XPROP: with RR_ARB_MUX_XPROP_EN, mode=1'bx, in_valid=4'b0001 -> in_ready=0; without macro -> grant 0, behaves as mode 0.
